// File: rtl/procyon_lib_pkg.sv
// Shared helpers for the procyon arbitration blocks: the index-width macro
// and a wrapped-index helper used by the round-robin logic.

`ifndef PCYN_C2I
`define PCYN_C2I(x) (((x) > 1) ? $clog2(x) : 1)
`endif

package procyon_lib_pkg;

    // (base + off) reduced modulo n, for walking a ring of n entries
    function automatic int pcyn_wrap_add(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/procyon_ff.sv
// Plain enabled register with no reset, used for payload (data/tag) storage.

module procyon_ff #(
    parameter int OPTN_DATA_WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       i_en,
    input  logic [OPTN_DATA_WIDTH-1:0] i_d,
    output logic [OPTN_DATA_WIDTH-1:0] o_q
);

    // Capture the payload only when enabled; contents are meaningless until first load
    always_ff @(posedge clk) begin
        if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/procyon_rr_picker.sv
// Multi-grant round-robin picker: scans requests starting at the pointer,
// wrapping at the top, and hands out up to OPTN_CDB_DEPTH one-hot grants in
// scan order (grant 0 is the first request found). Also reports whether any
// grant was made and the index of the last one granted.

`ifndef PCYN_C2I
`define PCYN_C2I(x) (((x) > 1) ? $clog2(x) : 1)
`endif

module procyon_rr_picker
    import procyon_lib_pkg::*;
#(
    parameter  int OPTN_NUM_FU    = 4,
    parameter  int OPTN_CDB_DEPTH = 2,
    localparam int PTR_W          = `PCYN_C2I(OPTN_NUM_FU)
) (
    input  logic [OPTN_NUM_FU-1:0] i_req,
    input  logic [PTR_W-1:0]       i_ptr,
    output logic [OPTN_NUM_FU-1:0] o_grant [0:OPTN_CDB_DEPTH-1],
    output logic                   o_any,
    output logic [PTR_W-1:0]       o_last
);

    int scan_idx;
    int grant_cnt;

    // Walk the ring from the pointer, giving each found request the next free bus
    always_comb begin
        scan_idx  = 0;
        grant_cnt = 0;
        o_any     = 1'b0;
        o_last    = i_ptr;
        for (int k = 0; k < OPTN_CDB_DEPTH; k++) begin
            o_grant[k] = '0;
        end
        for (int j = 0; j < OPTN_NUM_FU; j++) begin
            scan_idx = pcyn_wrap_add(int'(i_ptr), j, OPTN_NUM_FU);
            if (i_req[scan_idx] && (grant_cnt < OPTN_CDB_DEPTH)) begin
                o_grant[grant_cnt][scan_idx] = 1'b1;
                grant_cnt                    = grant_cnt + 1;
                o_any                        = 1'b1;
                o_last                       = PTR_W'(scan_idx);
            end else begin
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/procyon_srff.sv
// Enabled register with asynchronous active-low reset to a fixed value,
// used for all control state (valid bits, enables, pointers).

module procyon_srff #(
    parameter int                         OPTN_DATA_WIDTH  = 1,
    parameter logic [OPTN_DATA_WIDTH-1:0] OPTN_RESET_VALUE = '0
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       i_en,
    input  logic [OPTN_DATA_WIDTH-1:0] i_d,
    output logic [OPTN_DATA_WIDTH-1:0] o_q
);

    // Control state: forced to its reset value the moment n_rst drops
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            o_q <= OPTN_RESET_VALUE;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/procyon_cdb_arbiter.sv
// Common data bus arbiter. Each functional unit owns a one-entry holding
// buffer; a request is the buffered result if present, otherwise the live FU
// output. Up to OPTN_CDB_DEPTH requests are granted per cycle in round-robin
// order and broadcast one cycle later. Ungranted live results are captured in
// the buffer and the FU is stalled until the buffer drains, so every result is
// broadcast exactly once. Flush drops everything in flight.

`ifndef PCYN_C2I
`define PCYN_C2I(x) (((x) > 1) ? $clog2(x) : 1)
`endif

module procyon_cdb_arbiter
    import procyon_lib_pkg::*;
#(
    parameter int OPTN_DATA_WIDTH    = 32,
    parameter int OPTN_ROB_IDX_WIDTH = 5,
    parameter int OPTN_CDB_DEPTH     = 2,
    parameter int OPTN_NUM_FU        = 4
) (
    input  logic                          clk,
    input  logic                          n_rst,
    input  logic                          i_flush,
    input  logic                          i_fu_valid [0:OPTN_NUM_FU-1],
    input  logic [OPTN_DATA_WIDTH-1:0]    i_fu_data  [0:OPTN_NUM_FU-1],
    input  logic [OPTN_ROB_IDX_WIDTH-1:0] i_fu_tag   [0:OPTN_NUM_FU-1],
    output logic                          o_fu_stall [0:OPTN_NUM_FU-1],
    output logic                          o_cdb_en   [0:OPTN_CDB_DEPTH-1],
    output logic [OPTN_DATA_WIDTH-1:0]    o_cdb_data [0:OPTN_CDB_DEPTH-1],
    output logic [OPTN_ROB_IDX_WIDTH-1:0] o_cdb_tag  [0:OPTN_CDB_DEPTH-1]
);

    localparam int PTR_W = `PCYN_C2I(OPTN_NUM_FU);
    localparam int DW    = OPTN_DATA_WIDTH;
    localparam int TW    = OPTN_ROB_IDX_WIDTH;

    // Holding buffers
    logic [OPTN_NUM_FU-1:0] buf_valid_q;
    logic [OPTN_NUM_FU-1:0] buf_valid_d;
    logic [OPTN_NUM_FU-1:0] buf_load;
    logic [DW-1:0]          buf_data_q [0:OPTN_NUM_FU-1];
    logic [DW-1:0]          buf_data_d [0:OPTN_NUM_FU-1];
    logic [TW-1:0]          buf_tag_q  [0:OPTN_NUM_FU-1];
    logic [TW-1:0]          buf_tag_d  [0:OPTN_NUM_FU-1];

    // Effective requests
    logic [OPTN_NUM_FU-1:0] req_valid;
    logic [DW-1:0]          req_data [0:OPTN_NUM_FU-1];
    logic [TW-1:0]          req_tag  [0:OPTN_NUM_FU-1];

    // Arbitration
    logic [OPTN_NUM_FU-1:0] grant [0:OPTN_CDB_DEPTH-1];
    logic                   gnt_any;
    logic [PTR_W-1:0]       gnt_last;
    logic [OPTN_NUM_FU-1:0] fu_granted;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [PTR_W-1:0]       rr_ptr_d;

    // CDB output registers
    logic [OPTN_CDB_DEPTH-1:0] cdb_en_q;
    logic [OPTN_CDB_DEPTH-1:0] cdb_en_d;
    logic [DW-1:0]             cdb_data_q [0:OPTN_CDB_DEPTH-1];
    logic [DW-1:0]             cdb_data_d [0:OPTN_CDB_DEPTH-1];
    logic [TW-1:0]             cdb_tag_q  [0:OPTN_CDB_DEPTH-1];
    logic [TW-1:0]             cdb_tag_d  [0:OPTN_CDB_DEPTH-1];

    // Pick buffered result over live FU output; a flush masks every request
    always_comb begin
        for (int i = 0; i < OPTN_NUM_FU; i++) begin
            req_valid[i]  = ~i_flush & (buf_valid_q[i] | i_fu_valid[i]);
            req_data[i]   = buf_valid_q[i] ? buf_data_q[i] : i_fu_data[i];
            req_tag[i]    = buf_valid_q[i] ? buf_tag_q[i]  : i_fu_tag[i];
            buf_data_d[i] = i_fu_data[i];
            buf_tag_d[i]  = i_fu_tag[i];
        end
    end

    procyon_rr_picker #(
        .OPTN_NUM_FU    (OPTN_NUM_FU),
        .OPTN_CDB_DEPTH (OPTN_CDB_DEPTH)
    ) u_rr_picker (
        .i_req   (req_valid),
        .i_ptr   (rr_ptr_q),
        .o_grant (grant),
        .o_any   (gnt_any),
        .o_last  (gnt_last)
    );

    // Collapse per-bus grants into a per-FU "was granted" vector
    always_comb begin
        fu_granted = '0;
        for (int i = 0; i < OPTN_NUM_FU; i++) begin
            for (int k = 0; k < OPTN_CDB_DEPTH; k++) begin
                fu_granted[i] = fu_granted[i] | grant[k][i];
            end
        end
    end

    // Buffer keeps (or captures) any request that lost arbitration this cycle
    always_comb begin
        for (int i = 0; i < OPTN_NUM_FU; i++) begin
            buf_valid_d[i] = req_valid[i] & ~fu_granted[i];
            buf_load[i]    = ~buf_valid_q[i] & req_valid[i] & ~fu_granted[i];
        end
    end

    // Route each bus's granted request onto its next-cycle CDB slot
    always_comb begin
        for (int k = 0; k < OPTN_CDB_DEPTH; k++) begin
            cdb_en_d[k]   = |grant[k];
            cdb_data_d[k] = '0;
            cdb_tag_d[k]  = '0;
            for (int i = 0; i < OPTN_NUM_FU; i++) begin
                if (grant[k][i]) begin
                    cdb_data_d[k] = cdb_data_d[k] | req_data[i];
                    cdb_tag_d[k]  = cdb_tag_d[k]  | req_tag[i];
                end else begin
                    cdb_data_d[k] = cdb_data_d[k];
                end
            end
        end
    end

    // Pointer moves just past the last winner; holds when idle, zeroes on flush
    always_comb begin
        if (i_flush) begin
            rr_ptr_d = '0;
        end else if (gnt_any) begin
            rr_ptr_d = PTR_W'(pcyn_wrap_add(int'(gnt_last), 1, OPTN_NUM_FU));
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    procyon_srff #(.OPTN_DATA_WIDTH(OPTN_NUM_FU)) u_buf_valid (
        .clk   (clk),
        .n_rst (n_rst),
        .i_en  (1'b1),
        .i_d   (buf_valid_d),
        .o_q   (buf_valid_q)
    );

    procyon_srff #(.OPTN_DATA_WIDTH(PTR_W)) u_rr_ptr (
        .clk   (clk),
        .n_rst (n_rst),
        .i_en  (1'b1),
        .i_d   (rr_ptr_d),
        .o_q   (rr_ptr_q)
    );

    procyon_srff #(.OPTN_DATA_WIDTH(OPTN_CDB_DEPTH)) u_cdb_en (
        .clk   (clk),
        .n_rst (n_rst),
        .i_en  (1'b1),
        .i_d   (cdb_en_d),
        .o_q   (cdb_en_q)
    );

    for (genvar i = 0; i < OPTN_NUM_FU; i++) begin : g_fu
        procyon_ff #(.OPTN_DATA_WIDTH(DW)) u_buf_data (
            .clk  (clk),
            .i_en (buf_load[i]),
            .i_d  (buf_data_d[i]),
            .o_q  (buf_data_q[i])
        );

        procyon_ff #(.OPTN_DATA_WIDTH(TW)) u_buf_tag (
            .clk  (clk),
            .i_en (buf_load[i]),
            .i_d  (buf_tag_d[i]),
            .o_q  (buf_tag_q[i])
        );

        assign o_fu_stall[i] = buf_valid_q[i];
    end

    for (genvar k = 0; k < OPTN_CDB_DEPTH; k++) begin : g_cdb
        // Payload only updates on a grant so idle buses keep their last value
        procyon_ff #(.OPTN_DATA_WIDTH(DW)) u_cdb_data (
            .clk  (clk),
            .i_en (cdb_en_d[k]),
            .i_d  (cdb_data_d[k]),
            .o_q  (cdb_data_q[k])
        );

        procyon_ff #(.OPTN_DATA_WIDTH(TW)) u_cdb_tag (
            .clk  (clk),
            .i_en (cdb_en_d[k]),
            .i_d  (cdb_tag_d[k]),
            .o_q  (cdb_tag_q[k])
        );

        assign o_cdb_en[k]   = cdb_en_q[k];
        assign o_cdb_data[k] = cdb_data_q[k];
        assign o_cdb_tag[k]  = cdb_tag_q[k];
    end

endmodule

// File: tb/tb_procyon_cdb_arbiter.sv
// Bench for procyon_cdb_arbiter (4 FUs, 2 CDBs): a table of per-cycle stimulus
// with hand-derived next-cycle expectations fed through a scoreboard queue,
// hand-written reset sequences, and a random exactly-once traffic phase.

module tb_procyon_cdb_arbiter;

    localparam int N  = 4;
    localparam int D  = 2;
    localparam int DW = 32;
    localparam int TW = 5;
    localparam int NV = 17;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          i_flush;
    logic          i_fu_valid [0:N-1];
    logic [DW-1:0] i_fu_data  [0:N-1];
    logic [TW-1:0] i_fu_tag   [0:N-1];
    logic          o_fu_stall [0:N-1];
    logic          o_cdb_en   [0:D-1];
    logic [DW-1:0] o_cdb_data [0:D-1];
    logic [TW-1:0] o_cdb_tag  [0:D-1];

    always #5 clk = ~clk;

    procyon_cdb_arbiter #(
        .OPTN_DATA_WIDTH    (DW),
        .OPTN_ROB_IDX_WIDTH (TW),
        .OPTN_CDB_DEPTH     (D),
        .OPTN_NUM_FU        (N)
    ) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_flush    (i_flush),
        .i_fu_valid (i_fu_valid),
        .i_fu_data  (i_fu_data),
        .i_fu_tag   (i_fu_tag),
        .o_fu_stall (o_fu_stall),
        .o_cdb_en   (o_cdb_en),
        .o_cdb_data (o_cdb_data),
        .o_cdb_tag  (o_cdb_tag)
    );

    typedef struct packed {
        logic [1:0]      en;
        logic [1:0][4:0] tag;
        logic [1:0][7:0] dat;
        logic [3:0]      stall;
    } exp_t;

    typedef struct packed {
        logic            flush;
        logic [3:0]      vld;
        logic [3:0][4:0] tag;
        logic [3:0][7:0] dat;
        exp_t            exp;
    } vec_t;

    vec_t     tbl [NV];
    exp_t     sb_q [$];
    int       errors = 0;
    int       checks = 0;
    logic [4:0] hold_tag [D];
    logic [7:0] hold_dat [D];
    logic       hold_ok  [D];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] cur_en();
        return {o_cdb_en[1], o_cdb_en[0]};
    endfunction

    function automatic logic [3:0] cur_stall();
        return {o_fu_stall[3], o_fu_stall[2], o_fu_stall[1], o_fu_stall[0]};
    endfunction

    function automatic vec_t mkv(input logic fl, input logic [3:0] vld,
                                 input logic [3:0][4:0] tag, input logic [3:0][7:0] dat,
                                 input logic [1:0] een, input logic [1:0][4:0] etag,
                                 input logic [1:0][7:0] edat, input logic [3:0] est);
        vec_t v;
        v.flush     = fl;
        v.vld       = vld;
        v.tag       = tag;
        v.dat       = dat;
        v.exp.en    = een;
        v.exp.tag   = etag;
        v.exp.dat   = edat;
        v.exp.stall = est;
        return v;
    endfunction

    task automatic drive_idle();
        i_flush = 1'b0;
        for (int j = 0; j < N; j++) begin
            i_fu_valid[j] = 1'b0;
            i_fu_tag[j]   = '0;
            i_fu_data[j]  = '0;
        end
    endtask

    task automatic apply(input vec_t v);
        i_flush = v.flush;
        for (int j = 0; j < N; j++) begin
            i_fu_valid[j] = v.vld[j];
            i_fu_tag[j]   = v.tag[j];
            i_fu_data[j]  = {24'h0, v.dat[j]};
        end
    endtask

    task automatic compare(input exp_t e, input int idx);
        chk($sformatf("v%0d_en", idx), 32'(cur_en()), 32'(e.en));
        chk($sformatf("v%0d_stall", idx), 32'(cur_stall()), 32'(e.stall));
        for (int k = 0; k < D; k++) begin
            if (e.en[k]) begin
                chk($sformatf("v%0d_tag%0d", idx, k), 32'(o_cdb_tag[k]), 32'(e.tag[k]));
                chk($sformatf("v%0d_data%0d", idx, k), o_cdb_data[k], {24'h0, e.dat[k]});
                hold_tag[k] = e.tag[k];
                hold_dat[k] = e.dat[k];
                hold_ok[k]  = 1'b1;
            end else if (hold_ok[k]) begin
                chk($sformatf("v%0d_hold_tag%0d", idx, k), 32'(o_cdb_tag[k]), 32'(hold_tag[k]));
                chk($sformatf("v%0d_hold_data%0d", idx, k), o_cdb_data[k], {24'h0, hold_dat[k]});
            end else begin
                hold_ok[k] = 1'b0;
            end
        end
    endtask

    // Random-phase FU model state
    int         seq_n   [N];
    logic       drv_v   [N];
    logic       st_drv  [N];
    int         seen    [32];
    logic       rnd_done;

    initial begin
        // Stimulus table: inputs for cycle N, expected CDB/stall after the next edge.
        // Tags/data are packed {FU3,FU2,FU1,FU0}, expectations {CDB1,CDB0}.
        tbl[0]  = mkv(1'b0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {8'h00, 8'h00, 8'h00, 8'hA5},
                      2'b01, {5'd0, 5'd3}, {8'h00, 8'hA5}, 4'b0000);
        tbl[1]  = mkv(1'b0, 4'b1000, {5'd9, 5'd0, 5'd0, 5'd0}, {8'h99, 8'h00, 8'h00, 8'h00},
                      2'b01, {5'd0, 5'd9}, {8'h00, 8'h99}, 4'b0000);
        tbl[2]  = mkv(1'b0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {8'h44, 8'h33, 8'h22, 8'h11},
                      2'b11, {5'd2, 5'd1}, {8'h22, 8'h11}, 4'b1100);
        tbl[3]  = mkv(1'b0, 4'b1100, {5'd4, 5'd3, 5'd0, 5'd0}, {8'h44, 8'h33, 8'h00, 8'h00},
                      2'b11, {5'd4, 5'd3}, {8'h44, 8'h33}, 4'b0000);
        tbl[4]  = mkv(1'b0, 4'b0000, '0, '0, 2'b00, '0, '0, 4'b0000);
        tbl[5]  = mkv(1'b0, 4'b0100, {5'd0, 5'd5, 5'd0, 5'd0}, {8'h00, 8'h55, 8'h00, 8'h00},
                      2'b01, {5'd0, 5'd5}, {8'h00, 8'h55}, 4'b0000);
        tbl[6]  = mkv(1'b0, 4'b1001, {5'd6, 5'd0, 5'd0, 5'd10}, {8'h66, 8'h00, 8'h00, 8'h0A},
                      2'b11, {5'd10, 5'd6}, {8'h0A, 8'h66}, 4'b0000);
        tbl[7]  = mkv(1'b0, 4'b0111, {5'd0, 5'd13, 5'd12, 5'd11}, {8'h00, 8'h0D, 8'h0C, 8'h0B},
                      2'b11, {5'd13, 5'd12}, {8'h0D, 8'h0C}, 4'b0001);
        tbl[8]  = mkv(1'b0, 4'b1111, {5'd15, 5'd14, 5'd7, 5'd11}, {8'h0F, 8'h0E, 8'h77, 8'h0B},
                      2'b11, {5'd11, 5'd15}, {8'h0B, 8'h0F}, 4'b0110);
        tbl[9]  = mkv(1'b0, 4'b0110, {5'd0, 5'd14, 5'd8, 5'd0}, {8'h00, 8'h0E, 8'h88, 8'h00},
                      2'b11, {5'd14, 5'd7}, {8'h0E, 8'h77}, 4'b0000);
        tbl[10] = mkv(1'b0, 4'b0010, {5'd0, 5'd0, 5'd8, 5'd0}, {8'h00, 8'h00, 8'h88, 8'h00},
                      2'b01, {5'd0, 5'd8}, {8'h00, 8'h88}, 4'b0000);
        tbl[11] = mkv(1'b0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd22}, {8'h00, 8'h00, 8'h00, 8'h22},
                      2'b01, {5'd0, 5'd22}, {8'h00, 8'h22}, 4'b0000);
        tbl[12] = mkv(1'b0, 4'b1111, {5'd19, 5'd18, 5'd17, 5'd16}, {8'h13, 8'h12, 8'h11, 8'h10},
                      2'b11, {5'd18, 5'd17}, {8'h12, 8'h11}, 4'b1001);
        tbl[13] = mkv(1'b1, 4'b1001, {5'd19, 5'd0, 5'd0, 5'd16}, {8'h13, 8'h00, 8'h00, 8'h10},
                      2'b00, '0, '0, 4'b0000);
        tbl[14] = mkv(1'b0, 4'b1010, {5'd21, 5'd0, 5'd20, 5'd0}, {8'h21, 8'h00, 8'h20, 8'h00},
                      2'b11, {5'd21, 5'd20}, {8'h21, 8'h20}, 4'b0000);
        tbl[15] = mkv(1'b1, 4'b1111, {5'd26, 5'd25, 5'd24, 5'd23}, {8'h26, 8'h25, 8'h24, 8'h23},
                      2'b00, '0, '0, 4'b0000);
        tbl[16] = mkv(1'b0, 4'b0000, '0, '0, 2'b00, '0, '0, 4'b0000);

        for (int k = 0; k < D; k++) begin
            hold_ok[k]  = 1'b0;
            hold_tag[k] = '0;
            hold_dat[k] = '0;
        end

        // Reset state
        n_rst = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        chk("reset_en", 32'(cur_en()), 32'd0);
        chk("reset_stall", 32'(cur_stall()), 32'd0);
        n_rst = 1'b1;
        @(negedge clk);
        chk("post_reset_en", 32'(cur_en()), 32'd0);

        // Table phase through the scoreboard
        for (int i = 0; i < NV; i++) begin
            if (sb_q.size() > 0) begin
                compare(sb_q.pop_front(), i - 1);
            end
            apply(tbl[i]);
            sb_q.push_back(tbl[i].exp);
            @(negedge clk);
        end
        compare(sb_q.pop_front(), NV - 1);

        // Reset pulsed mid-burst: buffered tags 28/29 must never appear
        i_flush = 1'b0;
        for (int j = 0; j < N; j++) begin
            i_fu_valid[j] = 1'b1;
            i_fu_tag[j]   = TW'(26 + j);
            i_fu_data[j]  = 32'(8'h60 + j);
        end
        @(negedge clk);
        chk("burst_en", 32'(cur_en()), 32'h3);
        chk("burst_tag0", 32'(o_cdb_tag[0]), 32'd26);
        chk("burst_tag1", 32'(o_cdb_tag[1]), 32'd27);
        chk("burst_stall", 32'(cur_stall()), 32'hC);
        i_fu_valid[0] = 1'b0;
        i_fu_valid[1] = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        chk("rst_async_en", 32'(cur_en()), 32'd0);
        chk("rst_async_stall", 32'(cur_stall()), 32'd0);
        drive_idle();
        @(negedge clk);
        n_rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst_release_en_c%0d", c), 32'(cur_en()), 32'd0);
            chk($sformatf("rst_release_stall_c%0d", c), 32'(cur_stall()), 32'd0);
        end
        i_fu_valid[2] = 1'b1;
        i_fu_tag[2]   = 5'd30;
        i_fu_data[2]  = 32'h30;
        @(negedge clk);
        chk("after_rst_en", 32'(cur_en()), 32'h1);
        chk("after_rst_tag0", 32'(o_cdb_tag[0]), 32'd30);
        chk("after_rst_data0", o_cdb_data[0], 32'h30);
        drive_idle();

        // Random traffic: every unique tag must be broadcast exactly once
        for (int i = 0; i < N; i++) begin
            seq_n[i]  = 0;
            drv_v[i]  = 1'b0;
            st_drv[i] = 1'b0;
        end
        for (int t = 0; t < 32; t++) begin
            seen[t] = 0;
        end
        rnd_done = 1'b0;
        for (int cyc = 0; cyc < 400 && !rnd_done; cyc++) begin
            @(negedge clk);
            for (int k = 0; k < D; k++) begin
                if (o_cdb_en[k]) begin
                    seen[o_cdb_tag[k]]++;
                    chk($sformatf("rand_data_tag%0d", o_cdb_tag[k]), o_cdb_data[k],
                        32'hC0DE_0000 | 32'(o_cdb_tag[k]));
                end
            end
            rnd_done = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (drv_v[i] && !st_drv[i]) begin
                    seq_n[i]++;
                    drv_v[i] = 1'b0;
                end
                if (!drv_v[i] && (seq_n[i] < 8) && ($urandom_range(0, 2) != 0)) begin
                    drv_v[i] = 1'b1;
                end
                i_fu_valid[i] = drv_v[i];
                i_fu_tag[i]   = TW'(i * 8 + (seq_n[i] % 8));
                i_fu_data[i]  = 32'hC0DE_0000 | 32'(i * 8 + (seq_n[i] % 8));
                st_drv[i]     = o_fu_stall[i];
                if (seq_n[i] < 8 || drv_v[i]) begin
                    rnd_done = 1'b0;
                end
            end
        end
        chk("rand_all_sent", 32'(rnd_done), 32'd1);
        drive_idle();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            for (int k = 0; k < D; k++) begin
                if (o_cdb_en[k]) begin
                    seen[o_cdb_tag[k]]++;
                end
            end
        end
        for (int t = 0; t < 32; t++) begin
            chk($sformatf("rand_once_tag%0d", t), 32'(seen[t]), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/procyon_cdb_arbiter.md
PROCYON_CDB_ARBITER -- requirements
Module: procyon_cdb_arbiter

Interface
REQ-001 SHALL have parameter OPTN_DATA_WIDTH, default 32: result data width.
REQ-002 SHALL have parameter OPTN_ROB_IDX_WIDTH, default 5: ROB tag width.
REQ-003 SHALL have parameter OPTN_CDB_DEPTH, default 2: number of CDB buses driven.
REQ-004 SHALL have parameter OPTN_NUM_FU, default 4: number of requesting functional units, at least OPTN_CDB_DEPTH.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port n_rst, input, 1: asynchronous active-low reset.
REQ-007 SHALL have port i_flush, input, 1: pipeline flush.
REQ-008 SHALL have port i_fu_valid[0:OPTN_NUM_FU-1], input, 1 each: FU result valid.
REQ-009 SHALL have port i_fu_data[0:OPTN_NUM_FU-1], input, OPTN_DATA_WIDTH each: FU result data.
REQ-010 SHALL have port i_fu_tag[0:OPTN_NUM_FU-1], input, OPTN_ROB_IDX_WIDTH each: FU destination ROB tag.
REQ-011 SHALL have port o_fu_stall[0:OPTN_NUM_FU-1], output, 1 each: FU must hold its output.
REQ-012 SHALL have ports o_cdb_en, o_cdb_data and o_cdb_tag, each [0:OPTN_CDB_DEPTH-1], outputs, widths 1, OPTN_DATA_WIDTH and OPTN_ROB_IDX_WIDTH: CDB broadcast.

Function
REQ-013 SHALL keep a one-entry holding buffer per FU (valid, data, tag).
REQ-014 SHALL form request i as buf_valid[i] ? buffer i : i_fu_valid[i] with i_fu_data[i]/i_fu_tag[i]; while buf_valid[i]=1, SHALL ignore i_fu_*[i].
REQ-015 SHALL grant up to OPTN_CDB_DEPTH requests per cycle in round-robin order, starting at rr_ptr and wrapping from OPTN_NUM_FU-1 to 0.
REQ-016 SHALL assign the k-th grant in round-robin order to CDB k (k=0 first).
REQ-017 SHALL register CDB outputs: a request granted in cycle N appears on o_cdb_* in cycle N+1; o_cdb_en[k]=0 for unused buses.
REQ-018 SHALL, after a cycle with grants, set rr_ptr to (last granted index + 1) mod OPTN_NUM_FU; with no grants, rr_ptr SHALL hold.
REQ-019 SHALL load buffer i at the clock edge when request i is from i_fu_* and not granted.
REQ-020 SHALL clear buffer i when buffer i is granted.
REQ-021 SHALL drive o_fu_stall[i] = buf_valid[i] (registered, no combinational path from inputs).
REQ-022 SHALL never drop a result and never broadcast one twice; each tag appears on the CDB exactly once.
REQ-023 SHALL, when i_flush=1, clear all buffers, force all o_cdb_en to 0 next cycle and reset rr_ptr to 0; SHALL ignore that cycle's requests.
REQ-024 SHALL grant all requests in the same cycle when the request count is at most OPTN_CDB_DEPTH, buffering nothing.
REQ-025 SHALL hold o_cdb_data/o_cdb_tag unchanged when the matching o_cdb_en=0 (data-enable only on grant).

Reset
REQ-026 SHALL, on n_rst=0 asynchronously, clear all buf_valid, o_cdb_en and o_fu_stall, and set rr_ptr=0.
REQ-027 SHALL NOT reset data/tag registers; their values are don't-care until first valid.
REQ-028 SHALL discard buffered results on reset asserted mid-operation, with no broadcast after reset release until a new request.

Structure
REQ-029 SHALL add no new package typedefs; index widths SHALL be derived with the shared PCYN_C2I macro from procyon_lib_pkg.
REQ-030 SHALL place multi-grant round-robin selection in sub-module procyon_rr_picker (inputs: request vector, pointer; outputs: up to OPTN_CDB_DEPTH one-hot grants).
REQ-031 SHALL build its registers from the shared procyon_ff/procyon_srff primitives.

Verification (NUM_FU=4, CDB_DEPTH=2)
REQ-032 SHALL cover: FU0 valid tag 3, data 0xA5 alone -> next cycle o_cdb_en[0]=1, tag 3, data 0xA5; o_cdb_en[1]=0; no stall.
REQ-033 SHALL cover: all four FUs valid, tags 1-4, rr_ptr=0 -> cycle N+1 CDB0=tag1, CDB1=tag2; FU2/FU3 stall; cycle N+2 CDB0=tag3, CDB1=tag4; stalls drop.
REQ-034 SHALL cover: rr_ptr=3 with FU3 and FU0 requesting -> CDB0=FU3, CDB1=FU0; rr_ptr becomes 1.
REQ-035 SHALL cover: FU1 buffered tag 7 while FU1 input shows tag 8 -> tag 7 broadcast first, tag 8 a later cycle, each exactly once.
REQ-036 SHALL cover: i_flush with two buffers full -> next cycle all o_cdb_en=0, all stalls 0, rr_ptr=0.
REQ-037 SHALL cover: n_rst pulsed low mid-burst -> outputs clear immediately; no stale tag broadcast after release.
